// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder.
// State encoding and counter sizing helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/Half_Adder.sv
// Single-bit half adder cell.
// Two of these plus an OR form one full-adder slice.
module Half_Adder (
  input  logic A,
  input  logic B,
  output logic SUM,
  output logic CARRY
);

  assign SUM   = A ^ B;
  assign CARRY = A & B;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one slice.
// Operands in and result out over valid/ready handshakes.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START_VALID,
  output logic             START_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic [WIDTH-1:0] RESULT,
  output logic             COUT,
  output logic             DONE_VALID,
  input  logic             DONE_READY
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sha_q, sha_d;
  logic [WIDTH-1:0] shb_q, shb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d;

  logic s1, c1, s2, c2, nxt_carry;

  Half_Adder u_ha1 (
    .A    (sha_q[0]),
    .B    (shb_q[0]),
    .SUM  (s1),
    .CARRY(c1)
  );

  Half_Adder u_ha2 (
    .A    (s1),
    .B    (carry_q),
    .SUM  (s2),
    .CARRY(c2)
  );

  assign nxt_carry = c1 | c2;

  assign START_READY = (state_q == S_IDLE);
  assign DONE_VALID  = (state_q == S_HOLD);
  assign RESULT      = res_q;
  assign COUT        = cout_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    res_d   = res_q;
    cout_d  = cout_q;
    unique case (state_q)
      S_IDLE: begin
        if (START_VALID && START_READY) begin
          sha_d   = A;
          shb_d   = B;
          carry_d = CIN;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // sum bit enters at the MSB so the last bit lands LSB-aligned
        res_d   = (res_q >> 1) | (WIDTH'(s2) << (WIDTH - 1));
        sha_d   = sha_q >> 1;
        shb_d   = shb_q >> 1;
        carry_d = nxt_carry;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          cout_d  = nxt_carry;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (DONE_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sha_q   <= '0;
      shb_q   <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: vector table, random ops vs A+B+CIN,
// handshake corner cases, and a WIDTH=1 instance.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       sv, dr, cin;
  logic [7:0] a, b;
  logic       sr, dv, cout;
  logic [7:0] res;

  logic       sv1, dr1, cin1;
  logic [0:0] a1, b1;
  logic       sr1, dv1, cout1;
  logic [0:0] res1;

  serial_adder #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST(rst),
    .START_VALID(sv), .START_READY(sr),
    .A(a), .B(b), .CIN(cin),
    .RESULT(res), .COUT(cout),
    .DONE_VALID(dv), .DONE_READY(dr)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .CLK(clk), .RST(rst),
    .START_VALID(sv1), .START_READY(sr1),
    .A(a1), .B(b1), .CIN(cin1),
    .RESULT(res1), .COUT(cout1),
    .DONE_VALID(dv1), .DONE_READY(dr1)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready8();
    int n = 0;
    while (!sr && n < 50) begin tick(); n++; end
    chk("start_ready_wait", 32'(sr), 32'd1);
  endtask

  task automatic wait_done8(output int lat);
    int n = 0;
    while (!dv && n < 100) begin tick(); n++; end
    lat = n;
    chk("done_valid_wait", 32'(dv), 32'd1);
  endtask

  // handshake then wait for DONE_VALID; lat counts edges after handshake
  task automatic op8(input logic [7:0] ia, input logic [7:0] ib,
                     input logic icin, input logic rdy,
                     output logic [7:0] ores, output logic ocout,
                     output int lat);
    wait_ready8();
    a = ia; b = ib; cin = icin; sv = 1'b1; dr = rdy;
    tick();
    sv = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    wait_done8(lat);
    ores = res; ocout = cout;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] res;
    logic       cout;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [7:0] r;
    logic       c;
    logic [8:0] model;
    int         lat;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h11, 8'h22, 1'b0, 8'h33, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};

    rst = 1'b1; sv = 1'b0; dr = 1'b0; a = '0; b = '0; cin = 1'b0;
    sv1 = 1'b0; dr1 = 1'b1; a1 = '0; b1 = '0; cin1 = 1'b0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_start_ready", 32'(sr), 32'd1);
    chk("rst_done_valid", 32'(dv), 32'd0);
    chk("rst_result", 32'(res), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);

    foreach (vecs[i]) begin
      op8(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1, r, c, lat);
      chk($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].res));
      chk($sformatf("vec%0d_cout", i), 32'(c), 32'(vecs[i].cout));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
      tick();
    end

    // RESULT/COUT retained in IDLE: last vector was 0x80+0x80
    tick(); tick();
    chk("idle_keep_result", 32'(res), 32'h00);
    chk("idle_keep_cout", 32'(cout), 32'd1);
    chk("idle_start_ready", 32'(sr), 32'd1);

    for (int i = 0; i < 30; i++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      model = 9'(ra) + 9'(rb) + 9'(rc);
      op8(ra, rb, rc, 1'b1, r, c, lat);
      chk($sformatf("rand%0d_sum", i), 32'({c, r}), 32'(model));
      tick();
    end

    // hold with DONE_READY low for 20 cycles
    op8(8'hA5, 8'h0F, 1'b1, 1'b0, r, c, lat);
    chk("hold_first_result", 32'({c, r}), 32'h0B5);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_stable", 32'({dv, sr, cout, res}), 32'({1'b1, 1'b0, 1'b0, 8'hB5}));
    end
    dr = 1'b1;
    tick();
    chk("hold_release_ready", 32'(sr), 32'd1);
    chk("hold_release_valid", 32'(dv), 32'd0);

    // START_VALID pulse during RUN must be ignored
    wait_ready8();
    a = 8'h5A; b = 8'h3C; cin = 1'b0; sv = 1'b1; dr = 1'b1;
    tick();
    sv = 1'b0;
    tick();
    a = 8'h11; b = 8'h22; sv = 1'b1;
    tick();
    sv = 1'b0;
    wait_done8(lat);
    chk("ignore_result", 32'(res), 32'h96);
    chk("ignore_cout", 32'(cout), 32'd0);
    tick();
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      if (dv) lat++;
      tick();
    end
    chk("ignore_no_queue", 32'(lat), 32'd0);
    op8(8'h11, 8'h22, 1'b0, 1'b1, r, c, lat);
    chk("after_ignore_result", 32'(r), 32'h33);
    tick();

    // reset on the 4th RUN cycle aborts
    wait_ready8();
    a = 8'hF0; b = 8'h0F; cin = 1'b1; sv = 1'b1; dr = 1'b1;
    tick();
    sv = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_start_ready", 32'(sr), 32'd1);
    chk("abort_done_valid", 32'(dv), 32'd0);
    chk("abort_result", 32'(res), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    lat = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (dv) lat++;
    end
    chk("abort_no_done", 32'(lat), 32'd0);

    // WIDTH=1 instance, all operand combinations
    for (int i = 0; i < 8; i++) begin
      int n;
      logic [1:0] exp2;
      exp2 = 2'(i[2]) + 2'(i[1]) + 2'(i[0]);
      n = 0;
      while (!sr1 && n < 20) begin tick(); n++; end
      a1 = i[2]; b1 = i[1]; cin1 = i[0]; sv1 = 1'b1;
      tick();
      sv1 = 1'b0;
      n = 0;
      while (!dv1 && n < 20) begin tick(); n++; end
      chk($sformatf("w1_%0d_sum", i), 32'({cout1, res1}), 32'(exp2));
      chk($sformatf("w1_%0d_latency", i), 32'(n), 32'd1);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around the team's existing Half_Adder cell; it consumes the cell's SUM/CARRY outputs one bit per clock.
- Accepts two operands plus carry-in over a valid/ready handshake.
- Adds LSB-first over WIDTH cycles using one full-adder slice (two Half_Adder instances, one OR) and a carry flip-flop.
- Presents the parallel result and carry-out over a second valid/ready handshake; used where area matters more than latency.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 1..32

Ports:
CLK  input  1  rising-edge clock; single clock domain
RST  input  1  synchronous, active-high reset
START_VALID  input  1  operands A, B, CIN valid this cycle
START_READY  output  1  block can accept operands (high only in IDLE)
A  input  WIDTH  operand A, sampled on START handshake
B  input  WIDTH  operand B, sampled on START handshake
CIN  input  1  carry-in, sampled on START handshake
RESULT  output  WIDTH  sum bits; valid while DONE_VALID is high
COUT  output  1  final carry-out; valid while DONE_VALID is high
DONE_VALID  output  1  result available
DONE_READY  input  1  downstream accepts result

Behaviour:
- Reset (RST high at a CLK edge): state goes to IDLE, bit counter to 0, carry FF to 0, shift registers to 0, RESULT to 0, COUT to 0, DONE_VALID to 0, START_READY to 1. Reset mid-RUN or mid-HOLD aborts the operation with no partial output.
- START_READY = (state == IDLE); it is a combinational decode of the state register.
- DONE_VALID = (state == HOLD); it is registered via the state.
- States:
  - IDLE: on START_VALID && START_READY, load A and B into shift registers, carry FF <= CIN, counter <= 0, go to RUN. Otherwise stay.
  - RUN: each cycle, the slice adds shA[0], shB[0] and carry.
    - HA1 = (shA[0], shB[0]); HA2 = (HA1.SUM, carry).
    - sum bit = HA2.SUM; next carry = HA1.CARRY | HA2.CARRY.
    - Sum bit is shifted into the MSB of the result register, which shifts right. shA and shB shift right. Counter increments.
    - When counter == WIDTH-1 this cycle, go to HOLD. COUT <= next carry, and RESULT holds all WIDTH bits aligned LSB at bit 0.
  - HOLD: RESULT and COUT are stable. On DONE_READY, go to IDLE. Without DONE_READY, stay indefinitely; outputs must not change.
- Latency: START handshake at cycle T gives DONE_VALID high from cycle T+WIDTH+1. Throughput is one operation per WIDTH+2 cycles minimum.
- START_VALID is ignored outside IDLE. Operands presented during RUN or HOLD are not captured and are not queued.
- A and B may change freely after the START handshake; they are sampled only at the handshake.
- WIDTH=1: RUN lasts exactly one cycle.
- Counter width is clog2(WIDTH)+1 bits; no wrap occurs within an operation.
- RESULT and COUT retain their last values in IDLE until the next operation completes. Only DONE_VALID qualifies them.
- Arithmetic: {COUT, RESULT} = A + B + CIN, unsigned, exact modulo 2^(WIDTH+1).

Decomposition:
- Shared package: state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_HOLD=2'd2, and a CNT_W derivation function.
- Sub-modules: two Half_Adder instances form the bit slice. No new sub-module is needed; the FSM, shift registers and counter live in serial_adder.

Test Plan:
- WIDTH=8; A=0x5A, B=0x3C, CIN=0, DONE_READY held 1 -> DONE_VALID rises exactly 9 cycles after the handshake, RESULT=0x96, COUT=0.
- A=0xFF, B=0x01, CIN=0 -> RESULT=0x00, COUT=1. A=0xFF, B=0x00, CIN=1 -> RESULT=0x00, COUT=1.
- DONE_READY held 0 for 20 cycles after DONE_VALID -> RESULT, COUT and DONE_VALID are stable and START_READY=0. Asserting DONE_READY returns to IDLE next cycle with START_READY=1.
- START_VALID pulsed with A=0x11, B=0x22 during RUN of the 0x5A+0x3C op -> ignored; result is still 0x96. The next accepted op, 0x11+0x22, gives 0x33.
- RST asserted on the 4th RUN cycle -> next cycle IDLE, DONE_VALID=0, RESULT=0, COUT=0, START_READY=1. No DONE pulse appears afterwards.
- WIDTH=1 build, all 8 combinations of A, B, CIN -> {COUT, RESULT} equals the 2-bit sum. DONE_VALID appears 2 cycles after the handshake.
